// File: rtl/dual_port_memory_initiator_if.sv
// Pipeline fetch/data request-response channels plus the memory read/write ports
// of dual_port_memory_initiator, bundled with initiator (master) and environment (slave) views.
interface dual_port_memory_initiator_if;
  localparam int unsigned DW = 32;

  logic          fetch_req_valid;
  logic          fetch_req_ready;
  logic [DW-1:0] fetch_addr;
  logic          fetch_rsp_valid;
  logic          fetch_rsp_ready;
  logic [DW-1:0] fetch_rsp_data;
  logic          fetch_rsp_fault;

  logic          data_req_valid;
  logic          data_req_ready;
  logic          data_req_write;
  logic [DW-1:0] data_req_addr;
  logic [DW-1:0] data_req_wdata;
  logic          data_rsp_valid;
  logic          data_rsp_ready;
  logic [DW-1:0] data_rsp_data;
  logic          data_rsp_fault;

  logic [DW-1:0] read_address_0;
  logic [DW-1:0] read_address_1;
  logic [DW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          write_enable;
  logic [DW-1:0] read_data_0;
  logic [DW-1:0] read_data_1;

  modport master (
    input  fetch_req_valid, fetch_addr, fetch_rsp_ready,
    input  data_req_valid, data_req_write, data_req_addr, data_req_wdata, data_rsp_ready,
    input  read_data_0, read_data_1,
    output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_fault,
    output data_req_ready, data_rsp_valid, data_rsp_data, data_rsp_fault,
    output read_address_0, read_address_1, write_address, write_data, write_enable
  );

  modport slave (
    output fetch_req_valid, fetch_addr, fetch_rsp_ready,
    output data_req_valid, data_req_write, data_req_addr, data_req_wdata, data_rsp_ready,
    output read_data_0, read_data_1,
    input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_fault,
    input  data_req_ready, data_rsp_valid, data_rsp_data, data_rsp_fault,
    input  read_address_0, read_address_1, write_address, write_data, write_enable
  );
endinterface

// File: rtl/dual_port_memory_initiator.sv
// Requester front end for the dual-port main memory: independent fetch and load/store
// channels, one request in flight each, with store->fetch forwarding and range faults.
module dual_port_memory_initiator #(
  parameter int unsigned DEPTH = 2048
) (
  input  logic                        clk,
  input  logic                        rst,
  dual_port_memory_initiator_if.master bus
);
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DATA  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t        f_state, f_next;
  state_t        d_state, d_next;

  logic [DW-1:0] f_addr_q;
  logic [DW-1:0] f_hold_q;
  logic [DW-1:0] f_fwd_data_q;
  logic          f_fwd_q;

  logic [DW-1:0] d_addr_q;
  logic [DW-1:0] d_wdata_q;
  logic [DW-1:0] d_hold_q;
  logic          d_write_q;

  logic          f_fault;
  logic          d_fault;
  logic          collide;
  logic [DW-1:0] f_data_c;
  logic [DW-1:0] d_data_c;

  // Fault is judged on the full 32-bit latched address
  assign f_fault = (f_addr_q >= DEPTH);
  assign d_fault = (d_addr_q >= DEPTH);

  // The memory reads old contents when a fetch and a store hit the same word together
  assign collide = (f_state == S_ISSUE) && (d_state == S_ISSUE) && d_write_q &&
                   !d_fault && (f_addr_q == d_addr_q);

  assign f_data_c = f_fault ? '0 : (f_fwd_q ? f_fwd_data_q : bus.read_data_0);
  assign d_data_c = (d_fault || d_write_q) ? '0 : bus.read_data_1;

  assign bus.read_address_0 = f_addr_q;
  assign bus.read_address_1 = d_addr_q;
  assign bus.write_address  = d_addr_q;
  assign bus.write_data     = d_wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_state <= S_IDLE;
      d_state <= S_IDLE;
    end else begin
      f_state <= f_next;
      d_state <= d_next;
    end
  end

  // Fetch channel request capture, forward flag and stall buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_addr_q     <= '0;
      f_hold_q     <= '0;
      f_fwd_data_q <= '0;
      f_fwd_q      <= 1'b0;
    end else begin
      if ((f_state == S_IDLE) && bus.fetch_req_valid) begin
        f_addr_q <= bus.fetch_addr;
      end
      if (f_state == S_ISSUE) begin
        f_fwd_q      <= collide;
        f_fwd_data_q <= d_wdata_q;
      end
      if ((f_state == S_DATA) && !bus.fetch_rsp_ready) begin
        f_hold_q <= f_data_c;
      end
    end
  end

  // Data channel request capture and stall buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_hold_q  <= '0;
      d_write_q <= 1'b0;
    end else begin
      if ((d_state == S_IDLE) && bus.data_req_valid) begin
        d_addr_q  <= bus.data_req_addr;
        d_wdata_q <= bus.data_req_wdata;
        d_write_q <= bus.data_req_write;
      end
      if ((d_state == S_DATA) && !bus.data_rsp_ready) begin
        d_hold_q <= d_data_c;
      end
    end
  end

  always_comb begin
    f_next              = f_state;
    bus.fetch_req_ready = 1'b0;
    bus.fetch_rsp_valid = 1'b0;
    bus.fetch_rsp_data  = '0;
    bus.fetch_rsp_fault = 1'b0;
    case (f_state)
      S_IDLE: begin
        bus.fetch_req_ready = 1'b1;
        if (bus.fetch_req_valid) f_next = S_ISSUE;
      end
      S_ISSUE: f_next = S_DATA;
      S_DATA: begin
        bus.fetch_rsp_valid = 1'b1;
        bus.fetch_rsp_data  = f_data_c;
        bus.fetch_rsp_fault = f_fault;
        f_next = bus.fetch_rsp_ready ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        bus.fetch_rsp_valid = 1'b1;
        bus.fetch_rsp_data  = f_hold_q;
        bus.fetch_rsp_fault = f_fault;
        if (bus.fetch_rsp_ready) f_next = S_IDLE;
      end
      default: f_next = S_IDLE;
    endcase
  end

  // Write strobe decodes straight from state so an async reset kills it at once
  always_comb begin
    d_next             = d_state;
    bus.data_req_ready = 1'b0;
    bus.data_rsp_valid = 1'b0;
    bus.data_rsp_data  = '0;
    bus.data_rsp_fault = 1'b0;
    bus.write_enable   = 1'b0;
    case (d_state)
      S_IDLE: begin
        bus.data_req_ready = 1'b1;
        if (bus.data_req_valid) d_next = S_ISSUE;
      end
      S_ISSUE: begin
        bus.write_enable = d_write_q && !d_fault;
        d_next = S_DATA;
      end
      S_DATA: begin
        bus.data_rsp_valid = 1'b1;
        bus.data_rsp_data  = d_data_c;
        bus.data_rsp_fault = d_fault;
        d_next = bus.data_rsp_ready ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        bus.data_rsp_valid = 1'b1;
        bus.data_rsp_data  = d_hold_q;
        bus.data_rsp_fault = d_fault;
        if (bus.data_rsp_ready) d_next = S_IDLE;
      end
      default: d_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_dual_port_memory_initiator.sv
// Bench for dual_port_memory_initiator: directed vector table, corner sequences and a
// randomized phase scored against a transaction-level model of memory and channels.
module tb_dual_port_memory_initiator;
  localparam int unsigned DEPTH = 2048;
  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 32;
  localparam int unsigned NV    = 12;

  typedef struct {
    logic          wr;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    int            stall;
    logic [DW-1:0] exp_data;
    logic          exp_fault;
  } vec_t;

  logic clk;
  logic rst;
  logic noise0;
  int   tests;
  int   fails;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  vec_t          vecs    [NV];

  // model state, owned by the monitor
  int            cyc;
  logic          mon_en;
  logic          f_busy, d_busy, f_hs, d_hs;
  int            f_acc, d_acc;
  logic [DW-1:0] f_a, d_a, d_wd, f_exp, d_exp, undo_val;
  logic          f_expf, d_expf, d_wr, d_flt;

  logic [DW-1:0] fd, dd, rd_data;
  logic          ff, df, rd_fault;

  dual_port_memory_initiator_if bus();

  dual_port_memory_initiator #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mem_rd(input logic [DW-1:0] a);
    return (a < DEPTH) ? mem[a[AW-1:0]] : 32'hBAD0_BAD0;
  endfunction

  // Memory with synchronous read; a read in the same cycle as a write sees old data
  always @(posedge clk) begin
    if (bus.write_enable && (bus.write_address < DEPTH))
      mem[bus.write_address[AW-1:0]] <= bus.write_data;
    bus.read_data_0 <= noise0 ? $urandom() : mem_rd(bus.read_address_0);
    bus.read_data_1 <= mem_rd(bus.read_address_1);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_addr();
    int sel;
    sel = int'($urandom_range(9, 0));
    if (sel < 6) return DW'($urandom_range(15, 0));
    if (sel < 8) return DW'($urandom_range(2050, 2044));
    return $urandom();
  endfunction

  // Per-cycle scoreboard: each accepted request yields one response two cycles later
  task automatic monitor();
    logic f_rdy, d_rdy, f_v, d_v, f_in, d_in;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (d_busy && d_wr && !d_flt && (cyc == d_acc)) ref_mem[d_a[AW-1:0]] = undo_val;
        f_busy = 1'b0; d_busy = 1'b0; f_hs = 1'b0; d_hs = 1'b0;
      end else if (mon_en) begin
        cyc++;
        f_rdy = !f_busy;
        d_rdy = !d_busy;
        f_v   = f_busy && (cyc >= f_acc + 2);
        d_v   = d_busy && (cyc >= d_acc + 2);
        chk("fetch_req_ready", 32'(bus.fetch_req_ready), 32'(f_rdy));
        chk("data_req_ready", 32'(bus.data_req_ready), 32'(d_rdy));
        chk("fetch_rsp_valid", 32'(bus.fetch_rsp_valid), 32'(f_v));
        chk("data_rsp_valid", 32'(bus.data_rsp_valid), 32'(d_v));
        if (f_v) begin
          chk("fetch_rsp_data", bus.fetch_rsp_data, f_exp);
          chk("fetch_rsp_fault", 32'(bus.fetch_rsp_fault), 32'(f_expf));
        end else chk("fetch_rsp_data_idle", bus.fetch_rsp_data, '0);
        if (d_v) begin
          chk("data_rsp_data", bus.data_rsp_data, d_exp);
          chk("data_rsp_fault", 32'(bus.data_rsp_fault), 32'(d_expf));
        end else chk("data_rsp_data_idle", bus.data_rsp_data, '0);
        if (f_busy && (cyc == f_acc + 1)) chk("read_address_0", bus.read_address_0, f_a);
        if (d_busy && (cyc == d_acc + 1) && !d_wr) chk("read_address_1", bus.read_address_1, d_a);
        chk("write_enable", 32'(bus.write_enable),
            32'(d_busy && (cyc == d_acc + 1) && d_wr && !d_flt));
        if (d_busy && (cyc == d_acc + 1) && d_wr && !d_flt) begin
          chk("write_address", bus.write_address, d_a);
          chk("write_data", bus.write_data, d_wd);
        end
        if (f_v && bus.fetch_rsp_ready) f_busy = 1'b0;
        if (d_v && bus.data_rsp_ready) d_busy = 1'b0;
        f_hs = bus.fetch_req_valid && f_rdy;
        d_hs = bus.data_req_valid && d_rdy;
        if (f_hs) begin
          f_in   = bus.fetch_addr < DEPTH;
          f_busy = 1'b1; f_acc = cyc; f_a = bus.fetch_addr; f_expf = !f_in;
          if (!f_in) f_exp = '0;
          else if (d_hs && bus.data_req_write && (bus.data_req_addr == bus.fetch_addr))
            f_exp = bus.data_req_wdata;
          else f_exp = ref_mem[bus.fetch_addr[AW-1:0]];
        end
        if (d_hs) begin
          d_in   = bus.data_req_addr < DEPTH;
          d_busy = 1'b1; d_acc = cyc; d_a = bus.data_req_addr; d_wd = bus.data_req_wdata;
          d_wr   = bus.data_req_write; d_flt = !d_in; d_expf = !d_in;
          if (d_wr || !d_in) d_exp = '0;
          else d_exp = ref_mem[d_a[AW-1:0]];
          if (d_wr && d_in) begin
            undo_val = ref_mem[d_a[AW-1:0]];
            ref_mem[d_a[AW-1:0]] = d_wd;
          end
        end
      end
    end
  endtask

  task automatic fetch_txn(input logic [DW-1:0] addr, input int stall,
                           output logic [DW-1:0] data, output logic fault);
    int n;
    bus.fetch_req_valid = 1'b1;
    bus.fetch_addr      = addr;
    bus.fetch_rsp_ready = (stall == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.fetch_req_ready && n < 50);
    chk("fetch_accept", 32'(bus.fetch_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.fetch_req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.fetch_rsp_valid && n < 50);
    chk("fetch_rsp_arrives", 32'(bus.fetch_rsp_valid), 32'd1);
    data  = bus.fetch_rsp_data;
    fault = bus.fetch_rsp_fault;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      noise0 = 1'b1;
      if (i == stall - 1) bus.fetch_rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    noise0 = 1'b0;
    bus.fetch_rsp_ready = 1'b1;
  endtask

  task automatic data_txn(input logic wr, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                          input int stall, output logic [DW-1:0] data, output logic fault);
    int n;
    bus.data_req_valid = 1'b1;
    bus.data_req_write = wr;
    bus.data_req_addr  = addr;
    bus.data_req_wdata = wdata;
    bus.data_rsp_ready = (stall == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.data_req_ready && n < 50);
    chk("data_accept", 32'(bus.data_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.data_req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.data_rsp_valid && n < 50);
    chk("data_rsp_arrives", 32'(bus.data_rsp_valid), 32'd1);
    data  = bus.data_rsp_data;
    fault = bus.data_rsp_fault;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (i == stall - 1) bus.data_rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.data_rsp_ready = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0; noise0 = 1'b0; mon_en = 1'b0; rst = 1'b1; cyc = 0;
    f_busy = 1'b0; d_busy = 1'b0; f_hs = 1'b0; d_hs = 1'b0; f_acc = 0; d_acc = 0;
    f_a = '0; d_a = '0; d_wd = '0; f_exp = '0; d_exp = '0; undo_val = '0;
    f_expf = 1'b0; d_expf = 1'b0; d_wr = 1'b0; d_flt = 1'b0;
    bus.fetch_req_valid = 1'b0; bus.fetch_addr = '0; bus.fetch_rsp_ready = 1'b1;
    bus.data_req_valid = 1'b0; bus.data_req_write = 1'b0; bus.data_req_addr = '0;
    bus.data_req_wdata = '0; bus.data_rsp_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[5] = 32'hDEADBEEF;    ref_mem[5] = 32'hDEADBEEF;
    mem[3] = 32'h0000_0001;   ref_mem[3] = 32'h0000_0001;
    mem[7] = 32'h0000_00AA;   ref_mem[7] = 32'h0000_00AA;
    mem[2047] = 32'h7FF7FF00; ref_mem[2047] = 32'h7FF7FF00;

    vecs[0]  = '{1'b0, 32'd5,          32'd0,        0, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b1, 32'd10,         32'h12345678, 0, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'd10,         32'd0,        2, 32'h12345678, 1'b0};
    vecs[3]  = '{1'b1, 32'd2048,       32'h99999999, 0, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 32'd2048,       32'd0,        0, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd0,        1, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'd2047,       32'd0,        2, 32'h7FF7FF00, 1'b0};
    vecs[7]  = '{1'b1, 32'd0,          32'hFFFFFFFF, 0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'd0,          32'd0,        0, 32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{1'b1, 32'd2047,       32'h13572468, 3, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'd2047,       32'd0,        0, 32'h13572468, 1'b0};
    vecs[11] = '{1'b0, 32'd20,         32'd0,        0, 32'h0,        1'b0};

    fork monitor(); join_none

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fetch_rsp_valid", 32'(bus.fetch_rsp_valid), 32'd0);
    chk("rst_data_rsp_valid", 32'(bus.data_rsp_valid), 32'd0);
    chk("rst_fetch_rsp_data", bus.fetch_rsp_data, '0);
    chk("rst_data_rsp_data", bus.data_rsp_data, '0);
    chk("rst_fetch_rsp_fault", 32'(bus.fetch_rsp_fault), 32'd0);
    chk("rst_data_rsp_fault", 32'(bus.data_rsp_fault), 32'd0);
    chk("rst_read_address_0", bus.read_address_0, '0);
    chk("rst_read_address_1", bus.read_address_1, '0);
    chk("rst_write_address", bus.write_address, '0);
    chk("rst_write_data", bus.write_data, '0);
    chk("rst_write_enable", 32'(bus.write_enable), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_fetch_ready", 32'(bus.fetch_req_ready), 32'd1);
    chk("post_rst_data_ready", 32'(bus.data_req_ready), 32'd1);
    @(posedge clk); #1;

    // Reset during the ISSUE cycle of a store
    bus.data_req_valid = 1'b1; bus.data_req_write = 1'b1;
    bus.data_req_addr = 32'd20; bus.data_req_wdata = 32'h55AA55AA; bus.data_rsp_ready = 1'b1;
    @(negedge clk);
    chk("midrst_accept_ready", 32'(bus.data_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.data_req_valid = 1'b0;
    chk("midrst_we_in_issue", 32'(bus.write_enable), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_we_async_drop", 32'(bus.write_enable), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.data_rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(bus.data_rsp_valid), 32'd0);
      chk("midrst_fetch_ready", 32'(bus.fetch_req_ready), 32'd1);
      chk("midrst_data_ready", 32'(bus.data_req_ready), 32'd1);
    end
    @(posedge clk); #1;

    // Directed load/store vector table
    for (int v = 0; v < int'(NV); v++) begin
      data_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].stall, rd_data, rd_fault);
      chk($sformatf("vec%0d_data", v), rd_data, vecs[v].exp_data);
      chk($sformatf("vec%0d_fault", v), 32'(rd_fault), 32'(vecs[v].exp_fault));
    end

    // Fetch and store to the same word accepted on the same edge
    fork
      fetch_txn(32'd3, 0, fd, ff);
      data_txn(1'b1, 32'd3, 32'hCAFE0000, 0, dd, df);
    join
    chk("collide_fetch_data", fd, 32'hCAFE0000);
    chk("collide_fetch_fault", 32'(ff), 32'd0);
    chk("collide_store_ack", dd, 32'd0);
    fetch_txn(32'd3, 0, fd, ff);
    chk("collide_mem_updated", fd, 32'hCAFE0000);

    // Consumer stall with changing memory read data
    fetch_txn(32'd7, 4, fd, ff);
    chk("backpressure_data", fd, 32'h000000AA);
    fetch_txn(32'hFFFFFFFF, 2, fd, ff);
    chk("fetch_fault_data", fd, 32'd0);
    chk("fetch_fault_flag", 32'(ff), 32'd1);

    // Randomized traffic on both channels
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (f_hs) bus.fetch_req_valid = 1'b0;
      if (d_hs) bus.data_req_valid = 1'b0;
      if (!bus.fetch_req_valid && ($urandom_range(1, 0) == 1)) begin
        bus.fetch_req_valid = 1'b1;
        bus.fetch_addr      = rand_addr();
      end
      if (!bus.data_req_valid && ($urandom_range(1, 0) == 1)) begin
        bus.data_req_valid = 1'b1;
        bus.data_req_write = 1'($urandom_range(1, 0));
        bus.data_req_addr  = rand_addr();
        bus.data_req_wdata = $urandom();
      end
      bus.fetch_rsp_ready = ($urandom_range(3, 0) != 0);
      bus.data_rsp_ready  = ($urandom_range(3, 0) != 0);
    end
    @(posedge clk); #1;
    if (f_hs) bus.fetch_req_valid = 1'b0;
    if (d_hs) bus.data_req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    bus.fetch_req_valid = 1'b0;
    bus.data_req_valid  = 1'b0;
    bus.fetch_rsp_ready = 1'b1;
    bus.data_rsp_ready  = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("drain_fetch_ready", 32'(bus.fetch_req_ready), 32'd1);
    chk("drain_data_ready", 32'(bus.data_req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dual_port_memory_initiator.md
# dual_port_memory_initiator

Requester-side front end for the dual-port main memory. It accepts instruction-fetch and load/store requests from the pipeline over valid/ready handshakes, drives the memory's two read ports and its write port, and returns responses with backpressure. Each channel allows one request in flight. The block forwards data when a fetch collides with a store, and flags out-of-range addresses. It sits between the pipeline stages and `dual_port_main_memory`.

## Interface
- `DEPTH`, default 2048: memory depth in 32-bit words. Addresses are word indices.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `fetch_req_valid` / `fetch_req_ready`  in / out  1: fetch request handshake.
- `fetch_addr`  in  32: fetch word address.
- `fetch_rsp_valid` / `fetch_rsp_ready`  out / in  1: fetch response handshake.
- `fetch_rsp_data`  out  32: fetched word.
- `fetch_rsp_fault`  out  1: fetch address was >= DEPTH. Valid with `fetch_rsp_valid`.
- `data_req_valid` / `data_req_ready`  in / out  1: load/store request handshake.
- `data_req_write`  in  1: 1 = store, 0 = load.
- `data_req_addr`, `data_req_wdata`  in  32: load/store word address; store data.
- `data_rsp_valid` / `data_rsp_ready`  out / in  1: data response handshake.
- `data_rsp_data`  out  32: load data. Always 0 for a store acknowledge.
- `data_rsp_fault`  out  1: data address was >= DEPTH.
- `read_address_0`, `read_address_1`  out  32: to memory read ports 0 (fetch) and 1 (load).
- `write_address`, `write_data`  out  32; `write_enable`  out  1: to memory write port.
- `read_data_0`, `read_data_1`  in  32: from memory. The memory has a synchronous read: data presented at edge E is valid after E.

## Operation
- The fetch and data channels are independent. Each has its own FSM: IDLE -> ISSUE -> DATA -> (HOLD) -> IDLE.
- **IDLE**
  - `*_req_ready` = 1.
  - On valid && ready at an edge: latch the address into `addr_q` (data channel also latches write/wdata) and go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `read_address_*` = `addr_q`.
  - Store: `write_enable` = 1, `write_address`/`write_data` = latched values.
  - Loads and fetches do not assert `write_enable`.
  - Go to DATA.
- **DATA**
  - `*_rsp_valid` = 1.
  - Data source: `read_data_*` for a load/fetch, 0 for a store, forwarded data if the forward flag is set.
  - `rsp_ready` = 1: go to IDLE.
  - `rsp_ready` = 0: capture the response into `hold_q` and go to HOLD.
- **HOLD**
  - `rsp_valid` = 1, data = `hold_q`, stable until accepted.
  - On `rsp_ready`: go to IDLE.
- **Fault**
  - Address >= DEPTH: request is still accepted and runs the full FSM.
  - `write_enable` stays 0. Response data = 0, `rsp_fault` = 1.
- **Collision forwarding**
  - Condition: fetch ISSUE coincides with a store ISSUE to the same in-range address.
  - The fetch response returns the new `write_data`, not the old memory content.
  - Forward flag and data are registered at the ISSUE->DATA edge.
- Load vs. store on the same address cannot coincide, since the data channel has only one request outstanding.
- `*_rsp_data` is 0 whenever `rsp_valid` = 0.

## Timing
- Request accepted at edge E0. Memory samples at E1. Response valid in the cycle after E1: 2-cycle latency, zero-wait consumer.
- Peak throughput per channel: one request per 3 cycles (IDLE, ISSUE, DATA). A consumer stall adds one cycle per stalled cycle.
- `req_ready` is 0 in ISSUE, DATA and HOLD. A request held on `req_valid` waits; it is not dropped.
- **Reset values:**
  - Both FSMs IDLE.
  - `*_req_ready` = 1 once `rst` deasserts.
  - `*_rsp_valid` = 0, `*_rsp_data` = 0, `*_rsp_fault` = 0.
  - `read_address_*` = 0, `write_address` = 0, `write_data` = 0, `write_enable` = 0.
- **Reset mid-operation:**
  - `write_enable` drops immediately (asynchronously).
  - An in-flight request is discarded; no response is produced.
- Both channels may accept on the same edge. Their responses may be valid in the same cycle.
- An address compare uses all 32 bits. A fault is determined from the latched address.

## Test plan
- Reset then single load: preload mem[5]=0xDEADBEEF. Load addr 5 accepted at edge 1 -> `data_rsp_valid`=1 with 0xDEADBEEF in the cycle after edge 2, `fault`=0.
- Store then load: store 0x12345678 to addr 10 -> `write_enable`=1 for exactly one cycle with addr 10, ack data 0. A following load of addr 10 returns 0x12345678.
- Collision: mem[3]=0x1. Fetch addr 3 and store 0xCAFE0000 to addr 3 accepted on the same edge -> `fetch_rsp_data`=0xCAFE0000.
- Backpressure: fetch addr 7 (mem=0xAA) with `fetch_rsp_ready`=0 for 4 cycles while `read_data_0` changes -> `fetch_rsp_data` holds 0xAA. `fetch_req_ready`=0 until accept; IDLE the cycle after.
- Fault: store to addr 2048 with DEPTH=2048 -> `write_enable` never 1, `data_rsp_fault`=1, data 0. Load of addr 0xFFFFFFFF -> data 0, fault 1.
- Reset mid-store: assert `rst` during ISSUE -> `write_enable` 0 immediately, no `data_rsp_valid`, both ready=1 after release.
